// File: rtl/exec_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM pipeline register.
// A RUN/HALTED state machine turns every later instruction into a bubble once a halt has been loaded.
module exec_stage #(
  parameter int FWD_EN = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] alu_in1,
  input  logic [31:0] alu_in2,
  input  logic [4:0]  rs_alu_in,
  input  logic [4:0]  rt_alu_in,
  input  logic [3:0]  alu_aluop,
  input  logic [4:0]  wsel,
  input  logic [1:0]  wdat_source,
  input  logic        branch_instr,
  input  logic        branch_if_zero,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr_npc,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemstore,
  input  logic        mem_fwd_wen,
  input  logic [4:0]  mem_fwd_wsel,
  input  logic [31:0] mem_fwd_wdat,
  input  logic        wb_fwd_wen,
  input  logic [4:0]  wb_fwd_wsel,
  input  logic [31:0] wb_fwd_wdat,
  input  logic        mem_stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_alu_out,
  output logic [4:0]  ex_wsel,
  output logic [1:0]  ex_wdat_source,
  output logic        ex_dmemREN,
  output logic        ex_dmemWEN,
  output logic [31:0] ex_dmemstore,
  output logic [31:0] ex_npc,
  output logic        ex_halt,
  output logic        halted,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        ex_ready
);

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_e;

  typedef enum logic {RUN, HALTED} state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_out;
    logic [4:0]  wsel;
    logic [1:0]  wdat_source;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemstore;
    logic [31:0] npc;
    logic        halt;
  } exmem_t;

  state_e      state_q;
  exmem_t      ex_q, ex_d;
  aluop_e      op;
  logic [31:0] op_a, op_b, st_data, alu_res;
  logic        zero, actual_taken, load;

  // MEM result is newer than WB, so it wins when both target the same register.
  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] dflt,
                                      input logic m_wen, input logic [4:0] m_sel, input logic [31:0] m_dat,
                                      input logic w_wen, input logic [4:0] w_sel, input logic [31:0] w_dat);
    if (FWD_EN != 0 && src != '0 && m_wen && m_sel == src) return m_dat;
    if (FWD_EN != 0 && src != '0 && w_wen && w_sel == src) return w_dat;
    return dflt;
  endfunction

  assign op_a    = fwd(rs_alu_in, alu_in1, mem_fwd_wen, mem_fwd_wsel, mem_fwd_wdat,
                       wb_fwd_wen, wb_fwd_wsel, wb_fwd_wdat);
  assign op_b    = fwd(rt_alu_in, alu_in2, mem_fwd_wen, mem_fwd_wsel, mem_fwd_wdat,
                       wb_fwd_wen, wb_fwd_wsel, wb_fwd_wdat);
  assign st_data = fwd(rt_alu_in, dmemstore, mem_fwd_wen, mem_fwd_wsel, mem_fwd_wdat,
                       wb_fwd_wen, wb_fwd_wsel, wb_fwd_wdat);
  assign op      = aluop_e'(alu_aluop);

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'b0, op_a < op_b};
      default:  alu_res = '0;
    endcase
  end

  assign zero         = (alu_res == '0);
  assign actual_taken = branch_instr & (branch_if_zero ? zero : ~zero);
  assign ex_ready     = ~mem_stall;
  assign halted       = (state_q == HALTED);
  assign redirect     = in_valid & ~flush & ex_ready & ~halted & branch_instr &
                        (actual_taken != branch_taken);
  assign redirect_pc  = redirect ? (actual_taken ? branch_target : instr_npc) : '0;
  assign load         = ~mem_stall & ~halted & ~flush & in_valid;

  always_comb begin
    ex_d = ex_q;
    if (!mem_stall) begin
      ex_d = '0;
      if (load) begin
        ex_d.valid       = 1'b1;
        ex_d.alu_out     = alu_res;
        ex_d.wsel        = wsel;
        ex_d.wdat_source = wdat_source;
        ex_d.dmemREN     = dmemREN;
        ex_d.dmemWEN     = dmemWEN;
        ex_d.dmemstore   = st_data;
        ex_d.npc         = instr_npc;
        ex_d.halt        = halt;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      ex_q    <= '0;
    end else begin
      ex_q <= ex_d;
      if (load && halt) state_q <= HALTED;
    end
  end

  assign ex_valid       = ex_q.valid;
  assign ex_alu_out     = ex_q.alu_out;
  assign ex_wsel        = ex_q.wsel;
  assign ex_wdat_source = ex_q.wdat_source;
  assign ex_dmemREN     = ex_q.dmemREN;
  assign ex_dmemWEN     = ex_q.dmemWEN;
  assign ex_dmemstore   = ex_q.dmemstore;
  assign ex_npc         = ex_q.npc;
  assign ex_halt        = ex_q.halt;

endmodule

// File: tb/tb_exec_stage.sv
// Randomized bench for exec_stage: two instances (forwarding on/off) share stimulus and are
// compared against a behavioural model of the EX/MEM register, branch resolution and halt state.
module tb_exec_stage;

  logic        CLK = 1'b0, RST;
  logic        in_valid, branch_instr, branch_if_zero, branch_taken, halt, dmemREN, dmemWEN;
  logic [31:0] alu_in1, alu_in2, branch_target, instr_npc, dmemstore;
  logic [4:0]  rs_alu_in, rt_alu_in, wsel;
  logic [3:0]  alu_aluop;
  logic [1:0]  wdat_source;
  logic        mem_fwd_wen, wb_fwd_wen, mem_stall, flush;
  logic [4:0]  mem_fwd_wsel, wb_fwd_wsel;
  logic [31:0] mem_fwd_wdat, wb_fwd_wdat;

  logic        o_valid[2], o_ren[2], o_wen[2], o_halt[2], o_halted[2], o_redir[2], o_ready[2];
  logic [31:0] o_alu[2], o_st[2], o_npc[2], o_rpc[2];
  logic [4:0]  o_wsel[2];
  logic [1:0]  o_src[2];

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [4:0]  wsel;
    logic [1:0]  src;
    logic        ren, wen;
    logic [31:0] st, npc;
    logic        h;
  } ex_t;

  ex_t  m[2];
  logic m_halted;
  int   n_checks = 0, n_pass = 0;

  always #5 CLK = ~CLK;

  exec_stage #(.FWD_EN(1)) dut_fwd (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .rs_alu_in(rs_alu_in), .rt_alu_in(rt_alu_in), .alu_aluop(alu_aluop), .wsel(wsel),
    .wdat_source(wdat_source), .branch_instr(branch_instr), .branch_if_zero(branch_if_zero),
    .branch_taken(branch_taken), .branch_target(branch_target), .instr_npc(instr_npc),
    .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemstore(dmemstore),
    .mem_fwd_wen(mem_fwd_wen), .mem_fwd_wsel(mem_fwd_wsel), .mem_fwd_wdat(mem_fwd_wdat),
    .wb_fwd_wen(wb_fwd_wen), .wb_fwd_wsel(wb_fwd_wsel), .wb_fwd_wdat(wb_fwd_wdat),
    .mem_stall(mem_stall), .flush(flush),
    .ex_valid(o_valid[0]), .ex_alu_out(o_alu[0]), .ex_wsel(o_wsel[0]), .ex_wdat_source(o_src[0]),
    .ex_dmemREN(o_ren[0]), .ex_dmemWEN(o_wen[0]), .ex_dmemstore(o_st[0]), .ex_npc(o_npc[0]),
    .ex_halt(o_halt[0]), .halted(o_halted[0]), .redirect(o_redir[0]), .redirect_pc(o_rpc[0]),
    .ex_ready(o_ready[0])
  );

  exec_stage #(.FWD_EN(0)) dut_nofwd (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .rs_alu_in(rs_alu_in), .rt_alu_in(rt_alu_in), .alu_aluop(alu_aluop), .wsel(wsel),
    .wdat_source(wdat_source), .branch_instr(branch_instr), .branch_if_zero(branch_if_zero),
    .branch_taken(branch_taken), .branch_target(branch_target), .instr_npc(instr_npc),
    .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemstore(dmemstore),
    .mem_fwd_wen(mem_fwd_wen), .mem_fwd_wsel(mem_fwd_wsel), .mem_fwd_wdat(mem_fwd_wdat),
    .wb_fwd_wen(wb_fwd_wen), .wb_fwd_wsel(wb_fwd_wsel), .wb_fwd_wdat(wb_fwd_wdat),
    .mem_stall(mem_stall), .flush(flush),
    .ex_valid(o_valid[1]), .ex_alu_out(o_alu[1]), .ex_wsel(o_wsel[1]), .ex_wdat_source(o_src[1]),
    .ex_dmemREN(o_ren[1]), .ex_dmemWEN(o_wen[1]), .ex_dmemstore(o_st[1]), .ex_npc(o_npc[1]),
    .ex_halt(o_halt[1]), .halted(o_halted[1]), .redirect(o_redir[1]), .redirect_pc(o_rpc[1]),
    .ex_ready(o_ready[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference model ----------------------------------------------------------
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      0: return a << sh;
      1: return a >> sh;
      2: return a + b;
      3: return a - b;
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      7: return ~(a | b);
      8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // k==0 is the forwarding instance
  function automatic logic [31:0] pick(input int k, input logic [4:0] r, input logic [31:0] d);
    if (k == 0 && r != 0 && mem_fwd_wen && mem_fwd_wsel == r) return mem_fwd_wdat;
    if (k == 0 && r != 0 && wb_fwd_wen && wb_fwd_wsel == r) return wb_fwd_wdat;
    return d;
  endfunction

  function automatic logic [31:0] result(input int k);
    return ref_alu(int'(alu_aluop), pick(k, rs_alu_in, alu_in1), pick(k, rt_alu_in, alu_in2));
  endfunction

  function automatic logic taken(input int k);
    if (!branch_instr) return 1'b0;
    return branch_if_zero ? (result(k) == 0) : (result(k) != 0);
  endfunction

  function automatic logic exp_redirect(input int k);
    return in_valid && !flush && !mem_stall && !m_halted && branch_instr && (taken(k) != branch_taken);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) m[k] = '{v: 0, alu: 0, wsel: 0, src: 0, ren: 0, wen: 0, st: 0, npc: 0, h: 0};
    m_halted = 1'b0;
  endtask

  task automatic model_edge();
    logic take;
    if (RST) begin model_reset(); return; end
    if (mem_stall) return;
    take = !m_halted && !flush && in_valid;
    for (int k = 0; k < 2; k++) begin
      if (take) m[k] = '{v: 1, alu: result(k), wsel: wsel, src: wdat_source, ren: dmemREN,
                         wen: dmemWEN, st: pick(k, rt_alu_in, dmemstore), npc: instr_npc, h: halt};
      else      m[k] = '{v: 0, alu: 0, wsel: 0, src: 0, ren: 0, wen: 0, st: 0, npc: 0, h: 0};
    end
    if (take && halt) m_halted = 1'b1;
  endtask

  task automatic cmp_comb();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("redirect[%0d]", k), o_redir[k], exp_redirect(k));
      check($sformatf("redirect_pc[%0d]", k), o_rpc[k],
            exp_redirect(k) ? (taken(k) ? branch_target : instr_npc) : 32'd0);
      check($sformatf("ex_ready[%0d]", k), o_ready[k], !mem_stall);
    end
  endtask

  task automatic cmp_regs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ex_valid[%0d]", k), o_valid[k], m[k].v);
      check($sformatf("ex_alu_out[%0d]", k), o_alu[k], m[k].alu);
      check($sformatf("ex_wsel[%0d]", k), o_wsel[k], m[k].wsel);
      check($sformatf("ex_wdat_source[%0d]", k), o_src[k], m[k].src);
      check($sformatf("ex_dmemREN[%0d]", k), o_ren[k], m[k].ren);
      check($sformatf("ex_dmemWEN[%0d]", k), o_wen[k], m[k].wen);
      check($sformatf("ex_dmemstore[%0d]", k), o_st[k], m[k].st);
      check($sformatf("ex_npc[%0d]", k), o_npc[k], m[k].npc);
      check($sformatf("ex_halt[%0d]", k), o_halt[k], m[k].h);
      check($sformatf("halted[%0d]", k), o_halted[k], m_halted);
    end
  endtask

  // Inputs are already driven (just after a falling edge); run one rising edge.
  task automatic step();
    #1 cmp_comb();
    @(posedge CLK);
    model_edge();
    #1 cmp_regs();
    @(negedge CLK);
  endtask

  task automatic nop();
    in_valid = 0; alu_in1 = 0; alu_in2 = 0; rs_alu_in = 0; rt_alu_in = 0; alu_aluop = 4'd2;
    wsel = 0; wdat_source = 0; branch_instr = 0; branch_if_zero = 0; branch_taken = 0;
    branch_target = 0; instr_npc = 0; halt = 0; dmemREN = 0; dmemWEN = 0; dmemstore = 0;
    mem_fwd_wen = 0; mem_fwd_wsel = 0; mem_fwd_wdat = 0; wb_fwd_wen = 0; wb_fwd_wsel = 0;
    wb_fwd_wdat = 0; mem_stall = 0; flush = 0;
  endtask

  task automatic rand_inputs();
    in_valid       = ($urandom_range(0, 7) != 0);
    rs_alu_in      = 5'($urandom_range(0, 7));
    rt_alu_in      = 5'($urandom_range(0, 7));
    alu_aluop      = 4'($urandom_range(0, 9));
    alu_in1        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    alu_in2        = ($urandom_range(0, 3) == 0) ? alu_in1 : $urandom;
    wsel           = 5'($urandom_range(0, 31));
    wdat_source    = 2'($urandom_range(0, 3));
    branch_instr   = ($urandom_range(0, 2) == 0);
    branch_if_zero = 1'($urandom_range(0, 1));
    branch_taken   = 1'($urandom_range(0, 1));
    branch_target  = $urandom;
    instr_npc      = $urandom;
    halt           = !branch_instr && ($urandom_range(0, 24) == 0);
    dmemREN        = 1'($urandom_range(0, 1));
    dmemWEN        = 1'($urandom_range(0, 1));
    dmemstore      = $urandom;
    mem_fwd_wen    = 1'($urandom_range(0, 1));
    mem_fwd_wsel   = 5'($urandom_range(0, 7));
    mem_fwd_wdat   = $urandom;
    wb_fwd_wen     = 1'($urandom_range(0, 1));
    wb_fwd_wsel    = 5'($urandom_range(0, 7));
    wb_fwd_wdat    = $urandom;
    mem_stall      = ($urandom_range(0, 3) == 0);
    flush          = ($urandom_range(0, 7) == 0);
  endtask

  // Reset raised between edges must clear the stage without any clock edge.
  task automatic async_reset();
    RST = 1'b1;
    #1 model_reset();
    check("async_rst_valid", o_valid[0], 1'b0);
    check("async_rst_halted", o_halted[0], 1'b0);
    cmp_regs();
    step();
    RST = 1'b0;
  endtask

  logic [31:0] held_alu;

  initial begin
    nop();
    RST = 1'b1;
    model_reset();
    #1 cmp_regs();
    step();
    RST = 1'b0;

    // ADD 5+7
    nop(); in_valid = 1; rs_alu_in = 3; alu_in1 = 5; alu_in2 = 7;
    step();
    check("add_valid", o_valid[0], 1'b1);
    check("add_result", o_alu[0], 32'd12);

    // MEM beats WB when both match rs
    nop(); in_valid = 1; rs_alu_in = 4; alu_in1 = 1; alu_in2 = 1;
    mem_fwd_wen = 1; mem_fwd_wsel = 4; mem_fwd_wdat = 32'h10;
    wb_fwd_wen = 1; wb_fwd_wsel = 4; wb_fwd_wdat = 32'h20;
    step();
    check("fwd_on", o_alu[0], 32'h11);
    check("fwd_off", o_alu[1], 32'd2);

    // BEQ mispredicted not-taken, then BNE correctly not-taken
    nop(); in_valid = 1; alu_aluop = 4'd3; alu_in1 = 9; alu_in2 = 9; branch_instr = 1;
    branch_if_zero = 1; branch_target = 32'h40; instr_npc = 32'h8;
    #1 check("beq_redirect", o_redir[0], 1'b1);
    check("beq_redirect_pc", o_rpc[0], 32'h40);
    step();
    branch_if_zero = 0;
    #1 check("bne_redirect", o_redir[0], 1'b0);
    check("bne_redirect_pc", o_rpc[0], 32'h0);
    step();

    // Stall holds EX/MEM; releasing cycle carries a flush
    nop(); in_valid = 1; rs_alu_in = 1; alu_in1 = 32'h100; alu_in2 = 32'h23;
    step();
    held_alu = o_alu[0];
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); mem_stall = 1;
      step();
      check("stall_hold_alu", o_alu[0], held_alu);
      check("stall_hold_valid", o_valid[0], 1'b1);
    end
    rand_inputs(); mem_stall = 0; flush = 1;
    step();
    check("flush_bubble", o_valid[0], 1'b0);

    // Halt, then a valid ADD is dropped, then async reset clears HALTED
    nop(); in_valid = 1; halt = 1;
    step();
    check("halt_ex_halt", o_halt[0], 1'b1);
    check("halt_halted", o_halted[0], 1'b1);
    nop(); in_valid = 1; alu_in1 = 3; alu_in2 = 4;
    step();
    check("halted_drop", o_valid[0], 1'b0);
    async_reset();
    check("reset_unhalt", o_halted[0], 1'b0);

    // Randomized traffic, with occasional asynchronous resets (including mid-stall)
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, m_halted ? 6 : 80) == 0) begin
        nop();
        async_reset();
      end else begin
        rand_inputs();
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter FWD_EN, default 1, meaning 1 enables MEM/WB operand forwarding and 0 passes decode operands through unchanged.
REQ-002 SHALL have port CLK  in  1  rising-edge clock.
REQ-003 SHALL have port RST  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have decode inputs: in_valid 1; alu_in1, alu_in2 word_t; rs_alu_in, rt_alu_in regbits_t; alu_aluop aluop_t; wsel regbits_t; wdat_source write_t; branch_instr, branch_if_zero, branch_taken 1; branch_target, instr_npc word_t; halt, dmemREN, dmemWEN 1; dmemstore word_t.
REQ-005 SHALL have forwarding inputs: mem_fwd_wen 1, mem_fwd_wsel regbits_t, mem_fwd_wdat word_t, wb_fwd_wen 1, wb_fwd_wsel regbits_t, wb_fwd_wdat word_t.
REQ-006 SHALL have control inputs: mem_stall 1 (MEM cannot accept, hold EX/MEM), flush 1 (kill instruction presented this cycle).
REQ-007 SHALL have registered outputs: ex_valid 1, ex_alu_out word_t, ex_wsel regbits_t, ex_wdat_source write_t, ex_dmemREN, ex_dmemWEN 1, ex_dmemstore word_t, ex_npc word_t, ex_halt 1, halted 1.
REQ-008 SHALL have combinational outputs: redirect 1, redirect_pc word_t, ex_ready 1 (stage accepts input this cycle).

Function
REQ-009 Forwarding: safe operand for rs = mem_fwd_wdat if FWD_EN, mem_fwd_wen, mem_fwd_wsel==rs_alu_in, rs_alu_in!=0; else wb_fwd_wdat under same rule with wb_*; else alu_in1. MEM priority over WB.
REQ-010 Same rule SHALL produce safe alu_in2 from rt_alu_in/alu_in2 and safe dmemstore from rt_alu_in/dmemstore; rt_alu_in==0 (immediate/no source) means no forwarding.
REQ-011 ALU SHALL implement every aluop_t (SLL, SRL, ADD, SUB, AND, OR, XOR, NOR, SLT signed, SLTU unsigned); shifts use in2[4:0] as amount on in1; ADD/SUB 32-bit wrap, no overflow trap.
REQ-012 zero = (ALU result == 0); actual_taken = branch_instr & (branch_if_zero ? zero : ~zero).
REQ-013 redirect SHALL be 1 iff in_valid & ~flush & ex_ready & ~halted & branch_instr & (actual_taken != branch_taken); redirect_pc = actual_taken ? branch_target : instr_npc; redirect_pc = 0 when redirect = 0.
REQ-014 ex_ready = ~mem_stall.
REQ-015 Two-state FSM RUN/HALTED; RUN->HALTED on the edge that loads a valid halt instruction into EX/MEM; HALTED left only by RST; halted = (state==HALTED).
REQ-016 EX/MEM register update per edge, priority order: mem_stall=1 -> hold all ex_* (flush ignored while stalled, decode must hold); else halted=1 -> load bubble; else flush=1 or in_valid=0 -> load bubble; else load instruction.
REQ-017 Loaded instruction: ex_valid=1, ex_alu_out=ALU result, ex_dmemstore=safe dmemstore, ex_npc=instr_npc, remaining ex_* copied from inputs.
REQ-018 Bubble: ex_valid=0, ex_dmemREN=0, ex_dmemWEN=0, ex_halt=0, ex_wsel=0; data fields 0.
REQ-019 Latency: one cycle input to ex_*; redirect same cycle as input; at most one instruction in flight.
REQ-020 Stall and forwarding data changing in same cycle: ALU result is not captured while stalled; captured value uses forwarding inputs of the releasing cycle.
REQ-021 Halt with branch in same instruction is impossible by encoding; redirect still gated by ~halted after HALTED.

Reset
REQ-022 On RST=1, asynchronously: state=RUN, halted=0, all ex_* = bubble values (REQ-018), ex_npc=0, ex_alu_out=0.
REQ-023 RST asserted mid-stall SHALL discard held instruction; first edge after RST deassert with mem_stall=0 loads normally.

Verification
REQ-024 ADD rs=3 alu_in1=5, alu_in2=7, no forwarding -> next cycle ex_valid=1, ex_alu_out=12.
REQ-025 rs=4, mem_fwd_wen=1 wsel=4 wdat=0x10, wb_fwd_wen=1 wsel=4 wdat=0x20, alu_in1=1, ADD alu_in2=1 -> ex_alu_out=0x11; with FWD_EN=0 -> 2.
REQ-026 BEQ SUB in1=in2=9, branch_taken=0, branch_target=0x40 -> redirect=1, redirect_pc=0x40 same cycle; BNE same operands, branch_taken=0 -> redirect=0.
REQ-027 mem_stall=1 for 3 cycles with changing inputs -> ex_* constant; deassert -> current input captured; flush=1 that cycle -> bubble.
REQ-028 halt instruction loaded -> ex_halt=1, halted=1 next cycle; subsequent valid ADD -> ex_valid=0; RST -> halted=0.
REQ-029 RST asserted between clock edges -> ex_valid=0, halted=0 immediately without clock edge.
